stream_decipher: RTL and testbench

STREAM_DECIPHER -- requirements
Module: stream_decipher

---
 rtl/stream_decipher.sv | 147 ++++++++++++++
 tb/tb_stream_decipher.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_decipher.sv
// Byte-wide LFSR stream decipher: 4-byte key load, optional warm-up, 1 byte/cycle XOR.
// Define STREAM_DECIPHER_WARMUP_EN to discard WARMUP_CYCLES keystream steps after key load.
`timescale 1ns/1ps
module stream_decipher #(
   parameter int WARMUP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] key_in,
   input  logic       key_we,
   input  logic [7:0] ct_in,
   input  logic       ct_valid,
   output logic       ready,
   output logic [7:0] pt_out,
   output logic       pt_valid,
   output logic       drop_err
);

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
   localparam logic [31:0] LFSR_SAFE = 32'hACE1_ACE1;

   typedef enum logic [1:0] {IDLE, KEYLOAD, WARMUP, RUN} state_t;

   if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warmup
      $error("WARMUP_CYCLES must be in 1..255");
   end

   state_t      state_q;
   logic [31:0] key_q;
   logic [1:0]  kcnt_q;
   logic [31:0] lfsr_q;
   logic        ready_q;
   logic [7:0]  pt_out_q;
   logic        pt_valid_q;
   logic        drop_err_q;
`ifdef STREAM_DECIPHER_WARMUP_EN
   logic [7:0]  wcnt_q;
`endif

   logic [31:0] key_d;
   logic [31:0] seed_d;
   logic [31:0] lfsr1_d;
   logic [31:0] lfsr8_d;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
   endfunction

   // Full key as it will be after this edge; seeding reads it so the 4th byte needs no extra cycle.
   always_comb begin
      key_d = key_q;
      key_d[{kcnt_q, 3'b000} +: 8] = key_in;
      seed_d  = (key_d == 32'h0) ? LFSR_SAFE : key_d;
      lfsr1_d = lfsr_step(lfsr_q);
      lfsr8_d = lfsr_q;
      for (int i = 0; i < 8; i++) begin
         lfsr8_d = lfsr_step(lfsr8_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         key_q      <= 32'h0;
         kcnt_q     <= 2'd0;
         lfsr_q     <= LFSR_SAFE;
         ready_q    <= 1'b0;
         pt_out_q   <= 8'h00;
         pt_valid_q <= 1'b0;
         drop_err_q <= 1'b0;
`ifdef STREAM_DECIPHER_WARMUP_EN
         wcnt_q     <= 8'd0;
`endif
      end else if (!ena) begin
         pt_valid_q <= 1'b0;
      end else begin
         pt_valid_q <= 1'b0;
         case (state_q)
            IDLE, RUN: begin
               if (key_we) begin
                  key_q      <= {24'h0, key_in};
                  kcnt_q     <= 2'd1;
                  state_q    <= KEYLOAD;
                  ready_q    <= 1'b0;
                  drop_err_q <= 1'b0;
               end else if (ct_valid) begin
                  if (state_q == RUN) begin
                     pt_out_q   <= ct_in ^ lfsr_q[7:0];
                     pt_valid_q <= 1'b1;
                     lfsr_q     <= lfsr8_d;
                  end else begin
                     drop_err_q <= 1'b1;
                  end
               end
            end
            KEYLOAD: begin
               if (ct_valid) begin
                  drop_err_q <= 1'b1;
               end
               if (key_we) begin
                  key_q <= key_d;
                  if (kcnt_q == 2'd3) begin
                     lfsr_q <= seed_d;
                     kcnt_q <= 2'd0;
`ifdef STREAM_DECIPHER_WARMUP_EN
                     state_q <= WARMUP;
                     wcnt_q  <= 8'd0;
`else
                     state_q <= RUN;
                     ready_q <= 1'b1;
`endif
                  end else begin
                     kcnt_q <= kcnt_q + 2'd1;
                  end
               end
            end
`ifdef STREAM_DECIPHER_WARMUP_EN
            WARMUP: begin
               if (ct_valid) begin
                  drop_err_q <= 1'b1;
               end
               lfsr_q <= lfsr1_d;
               if (wcnt_q == 8'(WARMUP_CYCLES - 1)) begin
                  wcnt_q  <= 8'd0;
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end else begin
                  wcnt_q <= wcnt_q + 8'd1;
               end
            end
`endif
            default: begin
               state_q <= IDLE;
               kcnt_q  <= 2'd0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign pt_out   = pt_out_q;
   assign pt_valid = pt_valid_q;
   assign drop_err = drop_err_q;

endmodule

// File: tb/tb_stream_decipher.sv
// Directed bench for stream_decipher with a small keystream reference model.
// Expectations follow STREAM_DECIPHER_WARMUP_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_stream_decipher;

   localparam int W = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] key_in = 8'h00;
   logic       key_we = 1'b0;
   logic [7:0] ct_in = 8'h00;
   logic       ct_valid = 1'b0;
   logic       ready;
   logic [7:0] pt_out;
   logic       pt_valid;
   logic       drop_err;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] m_lfsr;
   logic [7:0]  last_pt;

`ifdef STREAM_DECIPHER_WARMUP_EN
   localparam int WARM_EXP = W;
`else
   localparam int WARM_EXP = 0;
`endif

   stream_decipher #(.WARMUP_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .key_in(key_in), .key_we(key_we),
      .ct_in(ct_in), .ct_valid(ct_valid),
      .ready(ready), .pt_out(pt_out), .pt_valid(pt_valid), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_step(input logic [31:0] s);
      m_step = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic model_seed(input logic [31:0] k);
      m_lfsr = (k == 32'h0) ? 32'hACE1_ACE1 : k;
`ifdef STREAM_DECIPHER_WARMUP_EN
      repeat (W) m_lfsr = m_step(m_lfsr);
`endif
   endtask

   task automatic model_ks(output logic [7:0] ks);
      ks = m_lfsr[7:0];
      repeat (8) m_lfsr = m_step(m_lfsr);
   endtask

   task automatic load_bytes(input logic [31:0] k, input int first, input int last);
      for (int i = first; i < last; i++) begin
         key_in = k[8*i +: 8];
         key_we = 1'b1;
         tick();
         if (i == 0) check("drop_clr", {31'h0, drop_err}, 32'h0);
      end
      key_we = 1'b0;
      $display("[TB] key bytes %0d..%0d of %h loaded", first, last - 1, k);
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!ready && cyc < 1000) begin
         tick();
         cyc++;
      end
      if (!ready) check("ready_timeout", {31'h0, ready}, 32'h1);
   endtask

   task automatic send_ct(input logic [7:0] ct, input logic [7:0] exp, input string tag);
      logic [7:0] ks;
      model_ks(ks);
      ct_in    = ct;
      ct_valid = 1'b1;
      tick();
      ct_valid = 1'b0;
      check({tag, "_v"}, {31'h0, pt_valid}, 32'h1);
      check(tag, {24'h0, pt_out}, {24'h0, exp});
      last_pt = exp;
      $display("[TB] %s ct=%h pt=%h", tag, ct, pt_out);
   endtask

   task automatic send_pt(input logic [7:0] pt, input string tag);
      logic [7:0] ks;
      ks = m_lfsr[7:0];
      send_ct(pt ^ ks, pt, tag);
   endtask

   initial begin
      int cyc;
      int consec;
      logic [7:0] pt_tab [64];
      logic [7:0] ks;

      // Reset state
      repeat (2) tick();
      rst = 1'b0;
      check("rst_ready", {31'h0, ready}, 32'h0);
      check("rst_ptv", {31'h0, pt_valid}, 32'h0);
      check("rst_pt", {24'h0, pt_out}, 32'h0);
      check("rst_drop", {31'h0, drop_err}, 32'h0);

      // Drop in IDLE
      ct_in = 8'h55; ct_valid = 1'b1;
      tick();
      ct_valid = 1'b0;
      check("idle_drop_ptv", {31'h0, pt_valid}, 32'h0);
      check("idle_drop_err", {31'h0, drop_err}, 32'h1);

      // All-zero key falls back to the safe seed
      load_bytes(32'h0, 0, 4);
      model_seed(32'h0);
      wait_ready(cyc);
      check("warm_len", cyc, WARM_EXP);
`ifdef STREAM_DECIPHER_WARMUP_EN
      send_pt(8'h3C, "zk0");
      send_pt(8'hA5, "zk1");
`else
      send_ct(8'hE1, 8'h00, "zk0");
      send_ct(8'hAE, 8'h00, "zk1");
`endif
      tick();
      check("hold_ptv", {31'h0, pt_valid}, 32'h0);
      check("hold_pt", {24'h0, pt_out}, {24'h0, last_pt});

`ifdef STREAM_DECIPHER_WARMUP_EN
      // Drop during WARMUP, cleared by the next key load
      load_bytes(32'h0BAD_F00D, 0, 4);
      model_seed(32'h0BAD_F00D);
      ct_in = 8'h55; ct_valid = 1'b1;
      tick();
      ct_valid = 1'b0;
      check("warm_drop_ptv", {31'h0, pt_valid}, 32'h0);
      check("warm_drop_err", {31'h0, drop_err}, 32'h1);
      check("warm_ready", {31'h0, ready}, 32'h0);
      wait_ready(cyc);
      check("warm_len2", cyc + 1, W);
`endif

      // 64 back-to-back bytes under key 0x12345678
      load_bytes(32'h1234_5678, 0, 4);
      check("drop_after_load", {31'h0, drop_err}, 32'h0);
      model_seed(32'h1234_5678);
      wait_ready(cyc);
      check("warm_len3", cyc, WARM_EXP);
      consec = 0;
      for (int i = 0; i < 64; i++) begin
         pt_tab[i] = 8'($urandom_range(0, 255));
         model_ks(ks);
         ct_in    = pt_tab[i] ^ ks;
         ct_valid = 1'b1;
         tick();
         if (pt_valid) consec++;
         check("stream_pt", {24'h0, pt_out}, {24'h0, pt_tab[i]});
         $display("[TB] stream %0d ct=%h pt=%h", i, ct_in, pt_out);
      end
      ct_valid = 1'b0;
      check("stream_consec", consec, 64);

      // key_we and ct_valid together in RUN: key wins, byte silently dropped
      key_in = 8'hEF; key_we = 1'b1; ct_in = 8'h55; ct_valid = 1'b1;
      tick();
      key_we = 1'b0; ct_valid = 1'b0;
      check("coll_ptv", {31'h0, pt_valid}, 32'h0);
      check("coll_ready", {31'h0, ready}, 32'h0);
      check("coll_drop", {31'h0, drop_err}, 32'h0);
      load_bytes(32'hDEAD_BEEF, 1, 4);
      model_seed(32'hDEAD_BEEF);
      wait_ready(cyc);
      send_pt(8'h11, "coll_b0");
      send_pt(8'h22, "coll_b1");

      // Reset mid-KEYLOAD then a clean load
      load_bytes(32'h9999_AAAA, 0, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready", {31'h0, ready}, 32'h0);
      check("abort_ptv", {31'h0, pt_valid}, 32'h0);
      load_bytes(32'hCAFE_F00D, 0, 4);
      model_seed(32'hCAFE_F00D);
      wait_ready(cyc);
      check("abort_warm", cyc, WARM_EXP);
      send_pt(8'h00, "abort_b0");
      send_pt(8'hFF, "abort_b1");

      // ena low in RUN: strobes ignored, keystream frozen
      ena = 1'b0; ct_in = 8'h77; ct_valid = 1'b1; key_in = 8'h00; key_we = 1'b1;
      repeat (5) tick();
      check("freeze_ptv", {31'h0, pt_valid}, 32'h0);
      ct_valid = 1'b0; key_we = 1'b0; ena = 1'b1;
      check("freeze_ready", {31'h0, ready}, 32'h1);
      send_pt(8'h5A, "freeze_b0");

      // ena low mid-KEYLOAD ignores key strobes
      load_bytes(32'h0102_0304, 0, 2);
      ena = 1'b0; key_in = 8'hFF; key_we = 1'b1;
      repeat (5) tick();
      key_we = 1'b0; ena = 1'b1;
      load_bytes(32'h0102_0304, 2, 4);
      model_seed(32'h0102_0304);
      wait_ready(cyc);
      send_pt(8'hC3, "kfreeze_b0");

`ifdef STREAM_DECIPHER_WARMUP_EN
      // ena low for 5 cycles mid-WARMUP delays ready by exactly 5
      load_bytes(32'h7777_1111, 0, 4);
      model_seed(32'h7777_1111);
      repeat (3) tick();
      ena = 1'b0;
      repeat (5) tick();
      ena = 1'b1;
      wait_ready(cyc);
      check("ena_warm_len", cyc + 8, W + 5);
      send_pt(8'h96, "ena_warm_b0");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
